serial_bridge: RTL and testbench

//  Serial debug/load bridge: bus initiator on the CPU-side peripheral bus, the counterpart of the

---
 rtl/serial_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bridge.sv
// serial_bridge: serial command bridge that turns 8N1 byte commands into
// single-byte bus reads/writes and sends a one-byte reply.
module serial_bridge #(
    parameter int CLK_FREQ  = 25000000,
    parameter int SYM_RATE  = 9600,
    parameter int TO_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        cs,
    output logic        we,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic        busy
);
    localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
    localparam int SCW     = $clog2(SYM_CNT);
    localparam int TOW     = $clog2(TO_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_AH, S_GET_AL, S_GET_D, S_REQ,
        S_ACC, S_CAP, S_SEND, S_TXW1, S_TXW2
    } state_t;

    state_t         state, state_nx;
    logic           rx_stb, rx_err;
    logic [7:0]     rx_dat;
    logic           tx_start, tx_busy;
    logic [7:0]     ah, al, wd;
    logic [7:0]     reply, reply_nx;
    logic           is_wr, is_wr_nx;
    logic [TOW-1:0] to_cnt;
    logic           in_get, timeout, byte_ok, byte_bad;

    serial_bridge_rx #(.SYM_CNT(SYM_CNT), .SCW(SCW)) u_rx (
        .clk(clk), .rst(rst), .rx(rx), .stb(rx_stb), .err(rx_err), .dat(rx_dat)
    );

    serial_bridge_tx #(.SYM_CNT(SYM_CNT), .SCW(SCW)) u_tx (
        .clk(clk), .rst(rst), .start(tx_start), .dat(reply), .tx(tx), .busy(tx_busy)
    );

    assign byte_ok  = rx_stb & ~rx_err;
    assign byte_bad = rx_stb & rx_err;
    assign in_get   = (state == S_GET_AH) || (state == S_GET_AL) || (state == S_GET_D);
    assign timeout  = in_get && !rx_stb && (to_cnt == TOW'(TO_CYCLES - 1));

    assign bus_req = (state == S_REQ) || (state == S_ACC) || (state == S_CAP);
    assign cs      = (state == S_ACC);
    assign we      = cs & is_wr;
    assign busy    = (state != S_IDLE);

    // state register; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state decode, reply selection and transmit handshake
    always_comb begin
        state_nx = state;
        reply_nx = reply;
        is_wr_nx = is_wr;
        tx_start = 1'b0;
        case (state)
            S_IDLE: if (byte_ok) begin
                if (rx_dat == 8'h57 || rx_dat == 8'h52) begin
                    is_wr_nx = (rx_dat == 8'h57);
                    state_nx = S_GET_AH;
                end else begin
                    reply_nx = 8'h3F;
                    state_nx = S_SEND;
                end
            end
            S_GET_AH: begin
                if (byte_bad || timeout) state_nx = S_IDLE;
                else if (byte_ok)        state_nx = S_GET_AL;
            end
            S_GET_AL: begin
                if (byte_bad || timeout) state_nx = S_IDLE;
                else if (byte_ok)        state_nx = is_wr ? S_GET_D : S_REQ;
            end
            S_GET_D: begin
                if (byte_bad || timeout) state_nx = S_IDLE;
                else if (byte_ok)        state_nx = S_REQ;
            end
            S_REQ: if (bus_gnt) state_nx = S_ACC;
            S_ACC: begin
                if (is_wr) begin
                    reply_nx = 8'h4B;
                    state_nx = S_SEND;
                end else begin
                    state_nx = S_CAP;
                end
            end
            S_CAP: begin
                reply_nx = din;
                state_nx = S_SEND;
            end
            S_SEND: if (!tx_busy) begin
                tx_start = 1'b1;
                state_nx = S_TXW1;
            end
            S_TXW1: if (tx_busy)  state_nx = S_TXW2;
            S_TXW2: if (!tx_busy) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // inter-byte timeout: counts only while a command is partially received
    always_ff @(posedge clk) begin
        if (rst || !in_get || rx_stb) to_cnt <= '0;
        else                          to_cnt <= to_cnt + TOW'(1);
    end

    // bus address/data launch; held between accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            dout <= '0;
        end else if (state == S_REQ && bus_gnt) begin
            addr <= {ah, al};
            dout <= wd;
        end
    end

    // command field capture and reply holding register
    always_ff @(posedge clk) begin
        reply <= reply_nx;
        is_wr <= is_wr_nx;
        if (byte_ok) begin
            case (state)
                S_GET_AH: ah <= rx_dat;
                S_GET_AL: al <= rx_dat;
                S_GET_D:  wd <= rx_dat;
                default:  ;
            endcase
        end
    end
endmodule

// serial_bridge_rx: 8N1 receiver, mid-bit sampling, start on a falling edge.
module serial_bridge_rx #(
    parameter int SYM_CNT = 2604,
    parameter int SCW     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       stb,
    output logic       err,
    output logic [7:0] dat
);
    logic [2:0]     sync;
    logic           active;
    logic [SCW-1:0] cnt;
    logic [3:0]     bitn;

    // bit sampling: bitn 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge clk) begin
        stb <= 1'b0;
        if (rst) begin
            sync   <= 3'b111;
            active <= 1'b0;
            cnt    <= '0;
            bitn   <= '0;
            err    <= 1'b0;
        end else begin
            sync <= {sync[1:0], rx};
            if (!active) begin
                if (sync[2] && !sync[1]) begin
                    active <= 1'b1;
                    bitn   <= '0;
                    cnt    <= SCW'(SYM_CNT / 2 - 1);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - SCW'(1);
            end else begin
                cnt <= SCW'(SYM_CNT - 1);
                if (bitn == 4'd0) begin
                    if (sync[1]) active <= 1'b0;
                    else         bitn   <= 4'd1;
                end else if (bitn == 4'd9) begin
                    active <= 1'b0;
                    stb    <= 1'b1;
                    err    <= ~sync[1];
                end else begin
                    dat  <= {sync[1], dat[7:1]};
                    bitn <= bitn + 4'd1;
                end
            end
        end
    end
endmodule

// serial_bridge_tx: 8N1 transmitter; start is ignored while busy.
module serial_bridge_tx #(
    parameter int SYM_CNT = 2604,
    parameter int SCW     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dat,
    output logic       tx,
    output logic       busy
);
    logic [9:0]     sh;
    logic [SCW-1:0] cnt;
    logic [3:0]     bitn;

    assign tx = sh[0];

    // frame shifter: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '1;
            busy <= 1'b0;
            cnt  <= '0;
            bitn <= '0;
        end else if (!busy) begin
            if (start) begin
                sh   <= {1'b1, dat, 1'b0};
                busy <= 1'b1;
                cnt  <= SCW'(SYM_CNT - 1);
                bitn <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - SCW'(1);
        end else begin
            cnt <= SCW'(SYM_CNT - 1);
            sh  <= {1'b1, sh[9:1]};
            if (bitn == 4'd9) busy <= 1'b0;
            else              bitn <= bitn + 4'd1;
        end
    end
endmodule

// File: tb/tb_serial_bridge.sv
// tb_serial_bridge: table vectors, randomized commands against a
// command-level reference model, and hand-written corner sequences.
module tb_serial_bridge;
    localparam int CLK_FREQ = 80;
    localparam int SYM_RATE = 10;
    localparam int TO       = 300;
    localparam int SYM      = CLK_FREQ / SYM_RATE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        bus_gnt = 1'b1;
    logic [7:0]  din = 8'h00;
    wire         tx, bus_req, cs, we, busy;
    wire  [15:0] addr;
    wire  [7:0]  dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stb_cyc = 0;
    int cs_cyc  = 0;
    bit req_seen = 0;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } acc_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          n;
        logic        has_reply;
        logic [7:0]  reply;
        logic        has_acc;
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } vec_t;

    logic [7:0] tx_q[$];
    acc_t       acc_q[$];
    logic [7:0] mem [logic [15:0]];
    logic [7:0] model_mem [logic [15:0]];
    vec_t       tbl[8];

    serial_bridge #(.CLK_FREQ(CLK_FREQ), .SYM_RATE(SYM_RATE), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .cs(cs), .we(we), .addr(addr), .dout(dout), .din(din), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    // bus target: registered read data, recorded accesses
    always @(negedge clk) begin
        if (dut.rx_stb === 1'b1) stb_cyc = cyc;
        if (bus_req === 1'b1) req_seen = 1;
        if (cs === 1'b1) begin
            cs_cyc = cyc;
            acc_q.push_back('{w: we, a: addr, d: dout});
            if (we) mem[addr] = dout;
            else    din = mem.exists(addr) ? mem[addr] : init_val(addr);
        end
    end

    // serial receiver watching tx
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                repeat (SYM / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (SYM) @(negedge clk);
                    v[i] = tx;
                end
                repeat (SYM) @(negedge clk);
                tx_q.push_back(v);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (SYM) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (SYM) @(negedge clk);
        end
        rx = stop_bit;
        repeat (SYM) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b0, b1, b2, b3, input int n);
        logic [7:0] bs[4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        for (int i = 0; i < n; i++) send_byte(bs[i], 1'b1);
    endtask

    task automatic clear_obs();
        tx_q.delete();
        acc_q.delete();
        req_seen = 0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s/idle: busy=%b after %0d cycles, expected 0", nm, busy, k);
        end
        repeat (2 * SYM) @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (bus_req !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "/req_up"}, bus_req, 1);
    endtask

    task automatic check_result(input string nm, input bit has_reply, input logic [7:0] rep,
                                input bit has_acc, input logic w, input logic [15:0] a,
                                input logic [7:0] d, input bit chk_lat);
        chk({nm, "/txcnt"}, tx_q.size(), has_reply ? 1 : 0);
        if (has_reply && tx_q.size() > 0) chk({nm, "/txbyte"}, tx_q[0], rep);
        chk({nm, "/acccnt"}, acc_q.size(), has_acc ? 1 : 0);
        chk({nm, "/req_seen"}, req_seen, has_acc);
        if (has_acc && acc_q.size() > 0) begin
            chk({nm, "/we"}, acc_q[0].w, w);
            chk({nm, "/addr"}, acc_q[0].a, a);
            if (w) chk({nm, "/dout"}, acc_q[0].d, d);
            if (chk_lat) chk({nm, "/latency"}, cs_cyc - stb_cyc, 2);
        end
        chk({nm, "/bus_req_low"}, bus_req, 0);
        chk({nm, "/busy_low"}, busy, 0);
        clear_obs();
    endtask

    task automatic run_random(input int cnt);
        int          kind;
        logic [15:0] a;
        logic [7:0]  d, c;
        for (int r = 0; r < cnt; r++) begin
            kind = $urandom_range(0, 4);
            a    = 16'h4000 | 16'($urandom_range(0, 7));
            d    = 8'($urandom);
            clear_obs();
            if (kind <= 1) begin
                send_cmd(8'h57, a[15:8], a[7:0], d, 4);
                wait_idle("rand_wr");
                check_result("rand_wr", 1, 8'h4B, 1, 1'b1, a, d, 1);
                model_mem[a] = d;
            end else if (kind <= 3) begin
                send_cmd(8'h52, a[15:8], a[7:0], 8'h00, 3);
                wait_idle("rand_rd");
                check_result("rand_rd", 1, model_rd(a), 1, 1'b0, a, 8'h00, 1);
            end else begin
                c = d;
                if (c == 8'h57 || c == 8'h52) c = 8'h00;
                send_cmd(c, 8'h00, 8'h00, 8'h00, 1);
                wait_idle("rand_bad");
                check_result("rand_bad", 1, 8'h3F, 0, 1'b0, 16'h0, 8'h0, 0);
            end
        end
    endtask

    initial begin
        bit hold_ok;
        int k;

        mem[16'h8001] = 8'h5C;
        mem[16'h0000] = 8'h00;
        tbl[0] = '{8'h57, 8'h12, 8'h34, 8'hA5, 4, 1'b1, 8'h4B, 1'b1, 1'b1, 16'h1234, 8'hA5};
        tbl[1] = '{8'h52, 8'h80, 8'h01, 8'h00, 3, 1'b1, 8'h5C, 1'b1, 1'b0, 16'h8001, 8'h00};
        tbl[2] = '{8'h41, 8'h00, 8'h00, 8'h00, 1, 1'b1, 8'h3F, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[3] = '{8'h52, 8'h00, 8'h00, 8'h00, 3, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00};
        tbl[4] = '{8'h52, 8'h12, 8'h34, 8'h00, 3, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h1234, 8'h00};
        tbl[5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 1, 1'b1, 8'h3F, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[6] = '{8'h57, 8'hFF, 8'hFF, 8'h00, 4, 1'b1, 8'h4B, 1'b1, 1'b1, 16'hFFFF, 8'h00};
        tbl[7] = '{8'h52, 8'hFF, 8'hFF, 8'h00, 3, 1'b1, 8'h00, 1'b1, 1'b0, 16'hFFFF, 8'h00};

        // reset state
        repeat (4) @(negedge clk);
        chk("rst/bus_req", bus_req, 0);
        chk("rst/cs", cs, 0);
        chk("rst/we", we, 0);
        chk("rst/addr", addr, 0);
        chk("rst/dout", dout, 0);
        chk("rst/busy", busy, 0);
        chk("rst/tx", tx, 1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_obs();

        // table vectors, grant held high
        for (int i = 0; i < 8; i++) begin
            send_cmd(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, tbl[i].n);
            wait_idle("tbl");
            check_result($sformatf("tbl%0d", i), tbl[i].has_reply, tbl[i].reply,
                         tbl[i].has_acc, tbl[i].w, tbl[i].a, tbl[i].d, 1);
        end

        run_random(12);

        // partial command then silence: abandoned with no reply
        send_cmd(8'h57, 8'h12, 8'h00, 8'h00, 2);
        repeat (TO / 2) @(negedge clk);
        chk("to/busy_mid", busy, 1);
        repeat (2 * TO) @(negedge clk);
        chk("to/busy_after", busy, 0);
        check_result("to", 0, 8'h00, 0, 1'b0, 16'h0, 8'h0, 0);
        send_cmd(8'h52, 8'h00, 8'h10, 8'h00, 3);
        wait_idle("to_next");
        check_result("to_next", 1, init_val(16'h0010), 1, 1'b0, 16'h0010, 8'h0, 1);

        // inter-byte gap just inside the timeout
        send_byte(8'h52, 1'b1);
        repeat (TO - 120) @(negedge clk);
        send_cmd(8'h00, 8'h20, 8'h00, 8'h00, 2);
        wait_idle("gap");
        check_result("gap", 1, init_val(16'h0020), 1, 1'b0, 16'h0020, 8'h0, 1);

        // grant withheld; a stray byte during the wait is dropped
        bus_gnt = 1'b0;
        send_cmd(8'h57, 8'h21, 8'h43, 8'h99, 4);
        wait_req("gnt");
        send_byte(8'h52, 1'b1);
        hold_ok = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || cs !== 1'b0) hold_ok = 0;
        end
        chk("gnt/hold", hold_ok, 1);
        bus_gnt = 1'b1;
        chk("gnt/cs_same", cs, 0);
        @(negedge clk);
        chk("gnt/cs_next", cs, 1);
        chk("gnt/we_next", we, 1);
        wait_idle("gnt");
        check_result("gnt", 1, 8'h4B, 1, 1'b1, 16'h2143, 8'h99, 0);

        // reset while waiting for grant
        bus_gnt = 1'b0;
        send_cmd(8'h57, 8'h66, 8'h78, 8'h11, 4);
        wait_req("rstreq");
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq/bus_req", bus_req, 0);
        chk("rstreq/busy", busy, 0);
        chk("rstreq/tx", tx, 1);
        rst = 1'b0;
        bus_gnt = 1'b1;
        repeat (4) @(negedge clk);
        clear_obs();
        send_cmd(8'h52, 8'h66, 8'h78, 8'h00, 3);
        wait_idle("rstreq_next");
        check_result("rstreq_next", 1, init_val(16'h6678), 1, 1'b0, 16'h6678, 8'h0, 1);

        // reset while the reply is on the line
        send_cmd(8'h41, 8'h00, 8'h00, 8'h00, 1);
        k = 0;
        while (tx !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("rsttx/tx_started", tx, 0);
        repeat (3 * SYM) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rsttx/busy", busy, 0);
        chk("rsttx/tx", tx, 1);
        chk("rsttx/bus_req", bus_req, 0);
        rst = 1'b0;
        repeat (12 * SYM) @(negedge clk);
        clear_obs();
        send_cmd(8'h57, 8'h30, 8'h31, 8'h32, 4);
        wait_idle("rsttx_next");
        check_result("rsttx_next", 1, 8'h4B, 1, 1'b1, 16'h3031, 8'h32, 1);

        // framing error mid-command
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr/busy", busy, 0);
        repeat (12 * SYM) @(negedge clk);
        check_result("ferr", 0, 8'h00, 0, 1'b0, 16'h0, 8'h0, 0);
        send_cmd(8'h52, 8'h30, 8'h31, 8'h00, 3);
        wait_idle("ferr_next");
        check_result("ferr_next", 1, 8'h32, 1, 1'b0, 16'h3031, 8'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
